// File: rtl/serial_dac_if.sv
// serial_dac_if: control-side load handshake and status between the control FSM and the DAC writer
interface serial_dac_if;
    logic       en;
    logic       shdn;
    logic [7:0] data_in;
    logic       dac_rdy;
    logic       done;
    logic       pd_active;
    modport master(output en, shdn, data_in, input dac_rdy, done, pd_active);
    modport slave(input en, shdn, data_in, output dac_rdy, done, pd_active);
endinterface

// File: rtl/serial_dac.sv
// serial_dac: writes 16-bit frames to a DAC081S101-class DAC over sync/sclk/sdata, then holds sync high for a gap
module serial_dac #(
    parameter logic [1:0] PD_MODE    = 2'b01,
    parameter int         GAP_CYCLES = 2
) (
    input  logic          clk,
    input  logic          resetn,
    serial_dac_if.slave   bus,
    output logic          sclk,
    output logic          sync,
    output logic          sdata
);
    typedef enum logic [1:0] {RST, IDLE, SHIFT, GAP} state_t;
    state_t      state, state_d;
    logic [15:0] frame, frame_d;
    logic [3:0]  cnt, cnt_d;
    logic        clk_en, clk_en_d, sync_d, sdata_d, rdy, rdy_d, done, done_d, pd, pd_d, shdn_l, shdn_l_d;
    assign sclk          = clk & clk_en;
    assign bus.dac_rdy   = rdy;
    assign bus.done      = done;
    assign bus.pd_active = pd;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= RST;
            frame  <= '0;
            cnt    <= '0;
            clk_en <= 1'b0;
            sync   <= 1'b1;
            sdata  <= 1'b0;
            rdy    <= 1'b0;
            done   <= 1'b0;
            pd     <= 1'b0;
            shdn_l <= 1'b0;
        end else begin
            state  <= state_d;
            frame  <= frame_d;
            cnt    <= cnt_d;
            clk_en <= clk_en_d;
            sync   <= sync_d;
            sdata  <= sdata_d;
            rdy    <= rdy_d;
            done   <= done_d;
            pd     <= pd_d;
            shdn_l <= shdn_l_d;
        end
    end
    always_comb begin
        state_d  = state;
        frame_d  = frame;
        cnt_d    = cnt;
        clk_en_d = clk_en;
        sync_d   = sync;
        sdata_d  = sdata;
        rdy_d    = rdy;
        done_d   = 1'b0;
        pd_d     = pd;
        shdn_l_d = shdn_l;
        case (state)
            RST: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
            end
            IDLE: if (bus.en) begin
                frame_d  = bus.shdn ? {2'b00, PD_MODE, 8'h00, 4'h0} : {4'h0, bus.data_in, 4'h0};
                shdn_l_d = bus.shdn;
                sync_d   = 1'b0;
                clk_en_d = 1'b1;
                sdata_d  = frame_d[15];
                cnt_d    = '0;
                rdy_d    = 1'b0;
                state_d  = SHIFT;
            end
            SHIFT: if (cnt == 4'd15) begin
                sync_d   = 1'b1;
                clk_en_d = 1'b0;
                sdata_d  = 1'b0;
                done_d   = 1'b1;
                pd_d     = shdn_l;
                cnt_d    = '0;
                state_d  = GAP;
            end else begin
                frame_d = frame << 1;
                sdata_d = frame[14];
                cnt_d   = cnt + 4'd1;
            end
            GAP: if (cnt == 4'(GAP_CYCLES - 1)) begin
                rdy_d   = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt + 4'd1;
            end
            default: state_d = RST;
        endcase
    end
endmodule

// File: doc/serial_dac.md
Name: serial_dac

Overview:
- 3-wire serial transmitter that writes 8-bit codes to the board's SPI-style DAC (DAC081S101-class, 16-bit frame, SYNC active-low). Write-side counterpart of the 8-bit RSSI ADC reader.
- Accepts a code and a shutdown request from the control FSM through a single-cycle `en` handshake.
- Drives `sync`, a gated `sclk` and `sdata`, then enforces a minimum SYNC-high gap between frames.

Parameters:
- `PD_MODE`, default 2'b01: power-down mode bits sent when `shdn` is set. 01 = 1k to GND, 10 = 100k, 11 = Hi-Z; 00 is illegal.
- `GAP_CYCLES`, default 2: clk cycles `sync` stays high after a frame before `dac_rdy` reasserts. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; also the source of `sclk`
- `resetn`  in  1  asynchronous, active-low reset
- `en`  in  1  load request; sampled only while `dac_rdy`=1
- `shdn`  in  1  sampled with `en`; 1 = send power-down frame
- `data_in`  in  8  DAC code; sampled with `en`
- `dac_rdy`  out  1  block idle and able to accept `en`
- `done`  out  1  one-cycle pulse after the 16th bit is sent
- `pd_active`  out  1  DAC is in power-down per the last completed frame
- `sclk`  out  1  serial clock, `clk` AND `clk_en` (`clk_en` is registered)
- `sync`  out  1  frame select, active-low
- `sdata`  out  1  serial data, MSB first

Behaviour:
- Reset values: `sync`=1, `sclk` gated off (`clk_en`=0), `sdata`=0, `dac_rdy`=0, `done`=0, `pd_active`=0, counter=0, state RST.
- Reset is asynchronous and may occur mid-frame. `sync` rises and `sclk` stops immediately, the DAC discards the partial frame, and the block restarts from RST.
- Frame register: {2'b00, mode[1:0], code[7:0], 4'b0000}.
  - `shdn`=0: mode=00, code=`data_in`.
  - `shdn`=1: mode=`PD_MODE`, code=8'h00.
- Timing: `sdata` and `sync` update on `clk` rising edges. The DAC samples on the `sclk` falling edge, mid-bit.
- State RST: go to IDLE on the next cycle and set `dac_rdy`<=1.
- State IDLE: `dac_rdy`=1.
  - If `en`=1 in cycle T: load the frame, `sync`<=0, `clk_en`<=1, `sdata`<=frame[15], counter<=0, `dac_rdy`<=0, go to SHIFT.
  - If `en`=0: hold all outputs.
- State SHIFT: one bit per cycle. Cycles T+1..T+16 carry frame[15]..frame[0] on `sdata`, with `sync`=0 and exactly 16 `sclk` pulses.
  - Counter 0..14: `sdata`<=next bit, counter++.
  - Counter 15: `sync`<=1, `clk_en`<=0, `sdata`<=0, `done`<=1, `pd_active`<=`shdn` as latched, counter<=0, go to GAP.
- State GAP: `sync`=1, no `sclk`.
  - `done` is high in cycle T+17 only.
  - After `GAP_CYCLES` cycles, `dac_rdy`<=1 and go to IDLE. Ready is first visible at T+17+`GAP_CYCLES`.
- `en` while `dac_rdy`=0 is ignored. No queueing, no error flag.
- `data_in` and `shdn` are latched at the `en` edge; later changes do not affect the frame in flight.
- Back-to-back: `en` held high continuously gives one frame every 17+`GAP_CYCLES` cycles.
- `pd_active` changes only at frame completion:
  - 1 after a power-down frame;
  - 0 after a normal frame (any normal write wakes the DAC).
- `sclk` never toggles while `sync`=1.

Test Plan:
- Reset released, `GAP_CYCLES`=2 → `dac_rdy`=0 in the first cycle, 1 from the second. `sync`=1, `sclk` quiet.
- `en`=1, `data_in`=8'hA5, `shdn`=0 at cycle T → `sync` low T+1..T+16; `sdata` sequence 0,0,0,0,1,0,1,0,0,1,0,1,0,0,0,0; 16 `sclk` pulses; `done` at T+17; `dac_rdy` at T+19; `pd_active`=0.
- `en`=1, `shdn`=1, `data_in`=8'hFF → frame 16'h1000 shifted (`PD_MODE`=01, code ignored); `pd_active`=1 from T+17. Then `en`, `shdn`=0, `data_in`=8'h80 → frame 16'h0800; `pd_active` returns to 0.
- `en` held high with `data_in` changing every cycle → frames start every 19 cycles; each carries the value present at its start cycle; pulses of `en` mid-frame are ignored.
- `resetn` asserted at the 7th bit of a frame → `sync`=1 and `sclk` stopped in the same cycle. After release a new write of 8'h3C completes correctly.
